inst_encoder: RTL
=================

# inst_encoder

Instruction encoder and program loader for the MIPS R/I/J single-cycle core. It accepts one instruction per handshake as a mnemonic code plus register, immediate and target fields, and packs it into the 32-bit word the core's instruction decoder expects. It then writes the word into instruction memory at consecutive addresses, with a one-stage registered write port. It sits between the testbench or host loader and the instruction RAM, and is the encoding counterpart of the core's decode stage.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  opens a load session; honoured only in IDLE or DONE.
- finish  in  1  closes a session; honoured only in LOAD.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  encoder accepts fields this cycle.
- mnem  in  5  mnemonic code (see Operation).
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate or branch offset, passed through unmodified.
- target  in  26  jump target field.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written this session.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  1  sticky; set when an illegal mnemonic is consumed.

## Operation
- FSM states are IDLE, LOAD and DONE.
  - IDLE → LOAD on start.
  - LOAD → DONE on finish.
  - DONE → LOAD on start.
  - start clears count and err.
- in_ready = (state==LOAD) && (count < 2^ADDR_W). It is combinational and independent of in_valid.
- A transfer occurs on any cycle with in_valid && in_ready.
- Mnemonics 0-7 are R-type, encoded as {6'b000000, rs, rt, rd, 5'b00000, func}.
  - func: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, sltu 101011, sllv 000100.
- Mnemonics 8-15 are I-type, encoded as {op, rs, rt, imm}.
  - op: addi 001000, andi 001100, xori 001110, sltiu 001011, lw 100011, sw 101011, beq 000100, bne 000101.
- Mnemonics 16-17 are J-type, encoded as {op, target}.
  - op: j 000010, jal 000011.
- Fields not used by a format are ignored.
- Mnemonics 18-31 are illegal. The transfer is consumed and err is set. No write occurs and count is unchanged.
- Legal transfer: the encoded word is registered to imem_wdata, imem_addr gets count[ADDR_W-1:0], and count increments.
- Full: when count == 2^ADDR_W, in_ready is low and the FSM stays in LOAD until finish.
- finish in the same cycle as a transfer: the transfer is accepted and written, then the FSM enters DONE.
- start while in LOAD is ignored.

## Timing
- Reset: state=IDLE; imem_we, imem_addr, imem_wdata, count, busy, done and err all 0.
- Write latency is one cycle. A transfer at edge N gives imem_we=1 for cycle N+1, with the address equal to count before edge N.
- Throughput is one word per cycle back-to-back; imem_we may stay high on consecutive cycles.
- imem_we is low on every cycle not preceded by a legal transfer. imem_addr and imem_wdata hold their last values when imem_we is low.
- busy and done are registered and follow the state directly.
- count updates in the same edge as the transfer.
- rst_n low mid-session: the pending write is dropped (imem_we=0 on the next cycle) and everything returns to reset values.

## Test plan
- Reset, start, then add rs=1 rt=2 rd=3 → one cycle later imem_we=1, imem_addr=0, imem_wdata=0x00221820; count=1.
- Back-to-back transfers, with no idle cycle between them:
  - addi rs=0 rt=5 imm=0xFFFF → addr 0, data 0x2005FFFF.
  - beq rs=1 rt=2 imm=3 → addr 1, data 0x10220003.
  - jal target=0x40 → addr 2, data 0x0C000040.
  - imem_we stays high for all three cycles.
- mnem=20 between two legal instructions → err=1, no write for it, addresses 0 and 1 are contiguous, count=2; err holds until the next start.
- With ADDR_W=2, hold in_valid for 6 cycles → exactly 4 writes (addr 0-3), count=4, in_ready=0, state remains LOAD; finish then → done=1.
- finish asserted with a legal transfer → the word is written on the next cycle; done=1 and in_ready=0 after that edge; a later start → count=0, err=0, busy=1.
- rst_n low the cycle after a transfer → no imem_we pulse, count=0, state IDLE.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs MIPS R/I/J instruction fields into 32-bit words and loads them into instruction memory
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, finish     open a session (IDLE/DONE) / close it (LOAD)
//   in_valid/in_ready instruction handshake; in_ready is combinational
//   mnem              mnemonic: 0-7 R-type, 8-15 I-type, 16-17 J-type, 18-31 illegal
//   rs, rt, rd        register fields
//   imm, target       immediate / jump target fields
//   imem_we/addr/wdata registered instruction-memory write port
//   count             words written this session
//   busy, done, err   registered status; err is sticky until the next start
module inst_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state;
    logic [5:0]  func;
    logic [5:0]  iop;
    logic [31:0] enc;
    logic        legal;

    // count never exceeds 2^ADDR_W, so its top bit alone flags a full memory
    assign in_ready = (state == LOAD) && !count[ADDR_W];

    always_comb begin
        func = 6'b100000;
        iop  = 6'b001000;
        case (mnem[2:0])
            3'd0: func = 6'b100000;
            3'd1: func = 6'b100010;
            3'd2: func = 6'b100100;
            3'd3: func = 6'b100101;
            3'd4: func = 6'b100110;
            3'd5: func = 6'b100111;
            3'd6: func = 6'b101011;
            3'd7: func = 6'b000100;
        endcase
        case (mnem[2:0])
            3'd0: iop = 6'b001000;
            3'd1: iop = 6'b001100;
            3'd2: iop = 6'b001110;
            3'd3: iop = 6'b001011;
            3'd4: iop = 6'b100011;
            3'd5: iop = 6'b101011;
            3'd6: iop = 6'b000100;
            3'd7: iop = 6'b000101;
        endcase
        legal = mnem < 5'd18;
        enc = mnem < 5'd8  ? {6'b000000, rs, rt, rd, 5'b00000, func} :
              mnem < 5'd16 ? {iop, rs, rt, imm} :
              mnem < 5'd18 ? {5'b00001, mnem[0], target} : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= count[ADDR_W-1:0];
                            imem_wdata <= enc;
                            count      <= count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    // a transfer in the same cycle as finish is still written above
                    if (finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
